// File: rtl/controle_votacao.sv
// rtl/controle_votacao.sv - voting round controller with per-seat tally and result scan
//
// Runs one voting round: latches the alive mask, serves each alive seat in
// index order until it votes or abstains, then scans the tallies to find the
// most-voted seat.
//
// Ports:
//   clock          system clock, rising-edge active
//   reset          asynchronous active-low reset
//   iniciar        pulse, starts a round (accepted in INICIAL or RESULTADO)
//   vivos[7:0]     alive mask, latched at round start
//   alvo[2:0]      target of the current voter
//   voto           pulse, cast a vote for alvo
//   passa          pulse, current voter abstains
//   jogador_atual  seat currently being served
//   aguardando     high while waiting for the current voter
//   voto_invalido  one-cycle pulse when a vote is rejected
//   pronto         high while the round result is valid
//   eliminado      most-voted seat (meaningful when pronto=1, empate=0)
//   empate         tie or no votes cast (meaningful when pronto=1)
//   db_estado      state code for the debug display
module controle_votacao #(
  parameter int NUM_JOGADORES = 6
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       iniciar,
  input  logic [7:0] vivos,
  input  logic [2:0] alvo,
  input  logic       voto,
  input  logic       passa,
  output logic [2:0] jogador_atual,
  output logic       aguardando,
  output logic       voto_invalido,
  output logic       pronto,
  output logic [2:0] eliminado,
  output logic       empate,
  output logic [4:0] db_estado
);

  typedef enum logic [2:0] {
    INICIAL   = 3'd0,
    PROCURA   = 3'd1,
    AGUARDA   = 3'd2,
    REGISTRA  = 3'd3,
    APURA     = 3'd4,
    RESULTADO = 3'd5
  } estado_t;

  localparam int         MASK_I = (1 << NUM_JOGADORES) - 1;
  localparam logic [7:0] MASK   = MASK_I[7:0];
  localparam logic [2:0] ULTIMO = 3'(NUM_JOGADORES - 1);
  localparam logic [3:0] N4     = 4'(NUM_JOGADORES);

  estado_t    estado;
  logic [7:0] vivos_r;
  logic [3:0] tally [8];
  logic [2:0] alvo_r;
  logic [2:0] k;
  logic [3:0] max_r;
  logic [2:0] idx_r;
  logic       tie_r;

  logic       alvo_valido;
  logic       ultimo;
  logic [3:0] cand;
  logic [3:0] max_n;
  logic [2:0] idx_n;
  logic       tie_n;

  assign alvo_valido = ({1'b0, alvo} < N4) && vivos_r[alvo];
  assign ultimo      = (jogador_atual == ULTIMO);
  assign cand        = tally[k];

  // Scan step for the seat under k. A strictly greater count takes the lead
  // (so the lowest index wins among equals); an equal non-zero count marks a tie.
  always_comb begin
    max_n = max_r;
    idx_n = idx_r;
    tie_n = tie_r;
    if (cand > max_r) begin
      max_n = cand;
      idx_n = k;
      tie_n = 1'b0;
    end else if ((cand == max_r) && (max_r != 4'd0)) begin
      tie_n = 1'b1;
    end
  end

  assign aguardando = (estado == AGUARDA);
  assign pronto     = (estado == RESULTADO);
  assign db_estado  = {2'b00, estado};

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado        <= INICIAL;
      vivos_r       <= '0;
      alvo_r        <= '0;
      k             <= '0;
      max_r         <= '0;
      idx_r         <= '0;
      tie_r         <= 1'b0;
      jogador_atual <= '0;
      voto_invalido <= 1'b0;
      eliminado     <= '0;
      empate        <= 1'b0;
      for (int i = 0; i < 8; i++) tally[i] <= '0;
    end else begin
      voto_invalido <= 1'b0;
      case (estado)
        INICIAL, RESULTADO: begin
          if (iniciar) begin
            vivos_r       <= vivos & MASK;
            jogador_atual <= '0;
            k             <= '0;
            max_r         <= '0;
            idx_r         <= '0;
            tie_r         <= 1'b0;
            for (int i = 0; i < 8; i++) tally[i] <= '0;
            estado        <= PROCURA;
          end
        end
        PROCURA: begin
          if (vivos_r[jogador_atual]) begin
            estado <= AGUARDA;
          end else if (ultimo) begin
            estado <= APURA;
          end else begin
            jogador_atual <= jogador_atual + 3'd1;
          end
        end
        AGUARDA: begin
          // voto has priority; passa in the same cycle is dropped.
          if (voto) begin
            if (alvo_valido) begin
              alvo_r <= alvo;
              estado <= REGISTRA;
            end else begin
              voto_invalido <= 1'b1;
            end
          end else if (passa) begin
            if (ultimo) begin
              estado <= APURA;
            end else begin
              jogador_atual <= jogador_atual + 3'd1;
              estado        <= PROCURA;
            end
          end
        end
        REGISTRA: begin
          tally[alvo_r] <= tally[alvo_r] + 4'd1;
          if (ultimo) begin
            estado <= APURA;
          end else begin
            jogador_atual <= jogador_atual + 3'd1;
            estado        <= PROCURA;
          end
        end
        APURA: begin
          max_r <= max_n;
          idx_r <= idx_n;
          tie_r <= tie_n;
          if (k == ULTIMO) begin
            eliminado <= idx_n;
            empate    <= tie_n | (max_n == 4'd0);
            estado    <= RESULTADO;
          end else begin
            k <= k + 3'd1;
          end
        end
        default: estado <= INICIAL;
      endcase
    end
  end

endmodule
